// File: rtl/dir_cmd_sched.sv
// dir_cmd_sched: turns a stream of ASCII direction keys into one move per
// game tick. Illegal keys (duplicates and 180-degree reversals) are filtered,
// legal ones are queued in a small FIFO, and each accepted tick offers one
// move on a valid/ready handshake. When the queue is empty at a tick, the
// current direction is repeated. 'p'/'P' toggles pause.
module dir_cmd_sched #(
  parameter int          DEPTH    = 4,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dir_valid,
  input  logic [7:0]                 dir_char,
  input  logic                       tick,
  input  logic                       move_ready,
  output logic                       move_valid,
  output logic [1:0]                 move_dir,
  output logic [1:0]                 cur_dir,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       paused,
  output logic                       drop,
  output logic                       tick_miss
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            move_valid_q, move_valid_d;
  logic [1:0]      move_dir_q, move_dir_d;
  logic [1:0]      cur_dir_q, cur_dir_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            paused_q, paused_d;
  logic            drop_q, drop_d;
  logic            tick_miss_q, tick_miss_d;

  logic [1:0]      fifo_mem [DEPTH];

  logic            is_dir;
  logic            is_pause;
  logic [1:0]      char_dir;
  logic [AW-1:0]   tail_idx;
  logic [1:0]      ref_dir;
  logic            q_empty;
  logic            q_full;
  logic            legal;
  logic            handshake;
  logic            tick_acc;
  logic            pop;
  logic            push;
  logic [1:0]      next_move;

  // Decode the incoming byte into a direction or a pause toggle.
  always_comb begin
    is_dir   = 1'b0;
    is_pause = 1'b0;
    char_dir = 2'b00;
    case (dir_char)
      8'h77, 8'h57: begin is_dir = 1'b1; char_dir = 2'b00; end // w / W : UP
      8'h61, 8'h41: begin is_dir = 1'b1; char_dir = 2'b01; end // a / A : LEFT
      8'h73, 8'h53: begin is_dir = 1'b1; char_dir = 2'b10; end // s / S : DOWN
      8'h64, 8'h44: begin is_dir = 1'b1; char_dir = 2'b11; end // d / D : RIGHT
      8'h70, 8'h50: is_pause = 1'b1;                           // p / P
      default: ;
    endcase
  end

  // Filter, handshake and FIFO control. The reference for legality is the
  // newest queued move (pre-cycle), or the current direction if nothing is
  // queued; there is no bypass from a same-cycle pop.
  always_comb begin
    q_empty   = (count_q == '0);
    q_full    = (count_q == CW'(DEPTH));
    tail_idx  = wr_ptr_q - AW'(1);
    ref_dir   = q_empty ? cur_dir_q : fifo_mem[tail_idx];
    legal     = dir_valid && is_dir &&
                (char_dir != ref_dir) && (char_dir != (ref_dir ^ 2'b10));
    handshake = move_valid_q && move_ready;
    tick_acc  = tick && !paused_q && ((state_q == IDLE) || handshake);
    pop       = tick_acc && !q_empty;
    // A full queue still accepts a push when the same cycle pops an entry.
    push      = legal && (!q_full || pop);
    next_move = q_empty ? cur_dir_q : fifo_mem[rd_ptr_q];
  end

  // Next-state computation for the issue FSM, queue pointers and pulses.
  always_comb begin
    state_d      = state_q;
    move_valid_d = move_valid_q;
    move_dir_d   = move_dir_q;
    cur_dir_d    = cur_dir_q;
    paused_d     = paused_q ^ (dir_valid && is_pause);
    drop_d       = legal && q_full && !pop;
    tick_miss_d  = tick && !paused_q && !tick_acc;
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    wr_ptr_d     = wr_ptr_q + AW'(push);
    count_d      = count_q + CW'(push) - CW'(pop);

    if (tick_acc) begin
      state_d      = ISSUE;
      move_valid_d = 1'b1;
      move_dir_d   = next_move;
      cur_dir_d    = next_move;
    end else if (handshake) begin
      state_d      = IDLE;
      move_valid_d = 1'b0;
    end
  end

  // All control state, including the FSM, is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      move_valid_q <= 1'b0;
      move_dir_q   <= 2'b00;
      cur_dir_q    <= INIT_DIR;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      paused_q     <= 1'b0;
      drop_q       <= 1'b0;
      tick_miss_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_valid_q <= move_valid_d;
      move_dir_q   <= move_dir_d;
      cur_dir_q    <= cur_dir_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      paused_q     <= paused_d;
      drop_q       <= drop_d;
      tick_miss_q  <= tick_miss_d;
    end
  end

  // Queue storage; contents are only meaningful between the pointers, so
  // no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= char_dir;
    end
  end

  assign move_valid = move_valid_q;
  assign move_dir   = move_dir_q;
  assign cur_dir    = cur_dir_q;
  assign q_count    = count_q;
  assign paused     = paused_q;
  assign drop       = drop_q;
  assign tick_miss  = tick_miss_q;

endmodule
